serial2para: RTL
================

Name: serial2para

Overview:
- Record-path deserializer for the audio codec's ADC serial stream.
- Receives a frame-pulse-delimited 32-bit slot, left word MSB first then right word, and presents parallel left/right samples with a one-cycle valid strobe.
- Sits between the codec pins (recdat, reclrc) and the synth/DSP logic.
- Uses the same internally generated bclk that drives the playback serializer; all logic runs on clk96M.

Parameters:
- WIDTH, 16, bits per channel sample; frame length is 2*WIDTH bits.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous pad inputs recdat and reclrc.

Ports:
- clk96M  input  1  system clock, 96 MHz.
- reset  input  1  asynchronous, active-high reset.
- bclk  input  1  bit clock level generated in the clk96M domain; high and low phases each ≥3 clk96M cycles.
- reclrc  input  1  codec frame pulse, high for one bclk period at frame start.
- recdat  input  1  codec serial data; changes on bclk falling edge.
- dout_L  output  WIDTH  last complete left sample.
- dout_R  output  WIDTH  last complete right sample.
- dvalid  output  1  one-cycle pulse when dout_L/dout_R update.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted: dout_L=0, dout_R=0, dvalid=0, shift register=0, bit counter=0, state IDLE. Sync flops also clear.
- Input alignment:
  - recdat and reclrc pass through SYNC_STAGES flops.
  - bclk passes through an equal-length delay so all three stay aligned.
  - rise = bclk_dly & ~bclk_prev, one cycle wide.
- Sampling happens only on cycles where rise=1. Nothing changes on other cycles except that dvalid clears.
- State machine:
  - IDLE: on rise with reclrc=1, shift in recdat as bit 2*WIDTH-1, set bitcnt=2*WIDTH-2, go to RECV. Bits without reclrc are ignored.
  - RECV, rise with reclrc=0: shift recdat in at the LSB, shifting left. At bitcnt=0, go to DONE; otherwise decrement bitcnt.
  - RECV, rise with reclrc=1 (early frame pulse): discard the partial frame and restart as on the IDLE entry. No dvalid.
  - DONE, single cycle: dout_L = sreg[2*WIDTH-1:WIDTH], dout_R = sreg[WIDTH-1:0], dvalid=1. Go to IDLE, or to RECV if this cycle is also a rise with reclrc=1 (back-to-back frames are never lost).
- Latency: dvalid asserts 2 clk96M cycles after the rise that samples the final LSB, plus SYNC_STAGES.
- dout_L/dout_R hold their value between frames; they are never partially updated.
- A bclk stuck high or low produces no rises. The block waits in its current state indefinitely, with no timeout.
- Reset mid-frame discards the partial frame; outputs return to 0.

Optional Feature:
- Macro S2P_SYNC_ERR_EN.
- Defined:
  - Adds output sync_err (1 bit), pulsed one cycle whenever an early frame pulse truncates a RECV frame.
  - Adds output err_cnt (8 bits), a saturating count of those events at 255, cleared by reset.
- Undefined: both ports and their logic are absent; early-pulse restart is still performed silently.

Decomposition:
- Package audio_pkg:
  - AUDIO_WIDTH=16
  - typedef sample_t (logic [AUDIO_WIDTH-1:0])
  - typedef enum s2p_state_t {IDLE, RECV, DONE}
  - shared by the serializer and deserializer.
- Sub-module bclk_edge_sync: pad synchronizers, the bclk alignment delay and the rise detector. It is reusable for the playback side.

Test Plan:
- Basic frame: bclk 4 high/4 low, one reclrc pulse, serial stream 0xA5C3_1234 MSB first -> exactly one dvalid, dout_L=16'hA5C3, dout_R=16'h1234.
- Back-to-back frames: 0x8001_7FFE then 0xFFFF_0000 with no gap -> two dvalid pulses 32 bclk periods apart, outputs correct each time, second frame's MSB not lost.
- Early frame pulse: reclrc reasserted after 20 bits, then full frame 0x0F0F_F0F0 -> a single dvalid with 0x0F0F/0xF0F0. With S2P_SYNC_ERR_EN: one sync_err pulse, err_cnt=1.
- No frame pulse: 100 bclk periods of random recdat, reclrc=0 -> dvalid never asserts, outputs stay 0.
- Reset mid-frame: reset asserted at bit 10 of a frame, released, then next frame 0x1111_2222 -> outputs 0 during reset, then 0x1111/0x2222 with one dvalid.
- Hold: after frame 0xDEAD_BEEF, bclk stopped for 1000 cycles -> dout_L=0xDEAD and dout_R=0xBEEF stable, dvalid=0 throughout.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path types for the codec serializer and deserializer.
// Sample width, sample type and the deserializer state encoding live here.
// No logic; pure declarations.
package audio_pkg;

  localparam int AUDIO_WIDTH = 16;

  typedef logic [AUDIO_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } s2p_state_t;

endpackage

// File: rtl/bclk_edge_sync.sv
// Pad synchronizers for codec lrc/data plus a matched-length bclk delay and rise detector.
// Latency: SYNC_STAGES cycles on all three inputs; rise is one cycle wide.
// No backpressure: free-running sampler.
module bclk_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic bclk,
  input  logic lrc,
  input  logic dat,
  output logic lrc_s,
  output logic dat_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] bclk_sr;
  logic [SYNC_STAGES-1:0] lrc_sr;
  logic [SYNC_STAGES-1:0] dat_sr;
  logic                   bclk_prev;

  // Equal-depth shift chains keep bclk, lrc and data aligned after synchronization.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_sr   <= '0;
      lrc_sr    <= '0;
      dat_sr    <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sr[0] <= bclk;
      lrc_sr[0]  <= lrc;
      dat_sr[0]  <= dat;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bclk_sr[i] <= bclk_sr[i-1];
        lrc_sr[i]  <= lrc_sr[i-1];
        dat_sr[i]  <= dat_sr[i-1];
      end
      bclk_prev <= bclk_sr[SYNC_STAGES-1];
    end
  end

  assign lrc_s = lrc_sr[SYNC_STAGES-1];
  assign dat_s = dat_sr[SYNC_STAGES-1];
  assign rise  = bclk_sr[SYNC_STAGES-1] & ~bclk_prev;

endmodule

// File: rtl/serial2para.sv
// Record-path deserializer: frame-pulse-delimited 2*WIDTH-bit slot -> parallel L/R samples.
// Latency: dvalid SYNC_STAGES+2 clk96M cycles after the pad bclk rise carrying the final LSB.
// No backpressure: dvalid is a one-cycle strobe; optional S2P_SYNC_ERR_EN adds sync_err/err_cnt.
module serial2para
  import audio_pkg::*;
#(
  parameter int WIDTH       = AUDIO_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk96M,
  input  logic             reset,
  input  logic             bclk,
  input  logic             reclrc,
  input  logic             recdat,
  output logic [WIDTH-1:0] dout_L,
  output logic [WIDTH-1:0] dout_R,
`ifdef S2P_SYNC_ERR_EN
  output logic             sync_err,
  output logic [7:0]       err_cnt,
`endif
  output logic             dvalid
);

  localparam int FRAME = 2 * WIDTH;
  localparam int CNT_W = $clog2(FRAME);

  logic             lrc_s;
  logic             dat_s;
  logic             rise;
  s2p_state_t       state;
  logic [FRAME-1:0] sreg;
  logic [CNT_W-1:0] bitcnt;

  bclk_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk96M),
    .rst  (reset),
    .bclk (bclk),
    .lrc  (reclrc),
    .dat  (recdat),
    .lrc_s(lrc_s),
    .dat_s(dat_s),
    .rise (rise)
  );

  // Frame FSM: a frame pulse always (re)starts capture with the first bit landing at
  // the LSB, so after the remaining 2*WIDTH-1 left shifts it sits at the MSB.
  always_ff @(posedge clk96M or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sreg   <= '0;
      bitcnt <= '0;
      dout_L <= '0;
      dout_R <= '0;
      dvalid <= 1'b0;
`ifdef S2P_SYNC_ERR_EN
      sync_err <= 1'b0;
      err_cnt  <= '0;
`endif
    end else begin
      dvalid <= 1'b0;
`ifdef S2P_SYNC_ERR_EN
      sync_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise && lrc_s) begin
            sreg   <= {{(FRAME-1){1'b0}}, dat_s};
            bitcnt <= CNT_W'(FRAME - 2);
            state  <= RECV;
          end
        end
        RECV: begin
          if (rise) begin
            if (lrc_s) begin
              // Early frame pulse: drop the partial frame and resync on this bit.
              sreg   <= {{(FRAME-1){1'b0}}, dat_s};
              bitcnt <= CNT_W'(FRAME - 2);
`ifdef S2P_SYNC_ERR_EN
              sync_err <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
            end else begin
              sreg <= {sreg[FRAME-2:0], dat_s};
              if (bitcnt == '0) state <= DONE;
              else bitcnt <= bitcnt - 1'b1;
            end
          end
        end
        DONE: begin
          dout_L <= sreg[FRAME-1:WIDTH];
          dout_R <= sreg[WIDTH-1:0];
          dvalid <= 1'b1;
          if (rise && lrc_s) begin
            // Next frame starts in the same cycle; capture its first bit.
            sreg   <= {{(FRAME-1){1'b0}}, dat_s};
            bitcnt <= CNT_W'(FRAME - 2);
            state  <= RECV;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
